// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the write-back cache and its controller.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL,
    DONE
  } state_t;

  function automatic int offset_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  // Bit 0 of the byte address is not part of any field.
  function automatic int tag_w(input int addr_w, input int sets, input int words);
    return addr_w - 1 - $clog2(sets) - $clog2(words);
  endfunction

endpackage

// File: rtl/cache_wb_fsm.sv
// Miss controller: dirty-line writeback, pipelined block refill with separate
// issue/receive counters, and the off-chip request muxing.
module cache_wb_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int SETS   = 64,
  parameter int WORDS  = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 victim_dirty,
  input  logic [tag_w(ADDR_W, SETS, WORDS)-1:0] victim_tag,
  input  logic [tag_w(ADDR_W, SETS, WORDS)-1:0] line_tag,
  input  logic [index_w(SETS)-1:0]             index,
  input  logic [DATA_W-1:0]                    wb_word,
  input  logic                                 mem_ready,
  input  logic                                 memory_data_valid,
  output state_t                               state,
  output logic [offset_w(WORDS)-1:0]           wb_offset,
  output logic [offset_w(WORDS)-1:0]           fill_offset,
  output logic                                 fill_we,
  output logic                                 fill_done,
  output logic                                 off_chip_rd,
  output logic                                 off_chip_wr,
  output logic [ADDR_W-1:0]                    off_chip_memory_address,
  output logic [DATA_W-1:0]                    off_chip_wr_data
);

  localparam int OFFSET_W = offset_w(WORDS);
  localparam logic [OFFSET_W:0] CNT_FULL = (OFFSET_W + 1)'(WORDS);
  localparam logic [OFFSET_W:0] CNT_LAST = (OFFSET_W + 1)'(WORDS - 1);

  logic [OFFSET_W:0]   issue_cnt;
  logic [OFFSET_W:0]   recv_cnt;
  logic [OFFSET_W-1:0] issue_off;

  assign issue_off   = issue_cnt[OFFSET_W-1:0];
  assign wb_offset   = issue_off;
  assign fill_offset = recv_cnt[OFFSET_W-1:0];
  assign fill_we     = (state == FILL) & memory_data_valid;
  assign fill_done   = fill_we & (recv_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
            state     <= victim_dirty ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            if (issue_cnt == CNT_LAST) begin
              issue_cnt <= '0;
              state     <= FILL;
            end else begin
              issue_cnt <= issue_cnt + 1'b1;
            end
          end
        end
        FILL: begin
          // Issue and receive run independently; responses may trail issues.
          if (mem_ready && issue_cnt != CNT_FULL) issue_cnt <= issue_cnt + 1'b1;
          if (memory_data_valid) begin
            recv_cnt <= recv_cnt + 1'b1;
            if (recv_cnt == CNT_LAST) state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    off_chip_rd             = 1'b0;
    off_chip_wr             = 1'b0;
    off_chip_memory_address = '0;
    off_chip_wr_data        = '0;
    case (state)
      WRITEBACK: begin
        off_chip_wr             = 1'b1;
        off_chip_memory_address = {victim_tag, index, issue_off, 1'b0};
        off_chip_wr_data        = wb_word;
      end
      FILL: begin
        if (issue_cnt != CNT_FULL) begin
          off_chip_rd             = 1'b1;
          off_chip_memory_address = {line_tag, index, issue_off, 1'b0};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cache_wb_memory_system.sv
// Set-associative write-back, write-allocate cache between a CPU port and DRAM.
// Holds the data/tag arrays, hit detection, LRU and victim selection.
module cache_wb_memory_system
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int SETS   = 64,
  parameter int WORDS  = 8,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              on_chip_wr,
  input  logic [ADDR_W-1:0] on_chip_memory_address,
  input  logic [DATA_W-1:0] on_chip_memory_data,
  output logic [DATA_W-1:0] data_out,
  output logic              fsm_busy,
  output logic [ADDR_W-1:0] off_chip_memory_address,
  output logic              off_chip_rd,
  output logic              off_chip_wr,
  output logic [DATA_W-1:0] off_chip_wr_data,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] off_chip_memory_data,
  input  logic              memory_data_valid
);

  localparam int OFFSET_W = offset_w(WORDS);
  localparam int INDEX_W  = index_w(SETS);
  localparam int TAG_W    = tag_w(ADDR_W, SETS, WORDS);

  logic [DATA_W-1:0] data_mem [WAYS][SETS*WORDS];
  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];

  logic [WAYS-1:0][SETS-1:0] valid_q;
  logic [WAYS-1:0][SETS-1:0] dirty_q;
  logic [SETS-1:0]           lru_q;
  logic                      victim_q;

  logic [OFFSET_W-1:0] offset;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic                addr_unused;

  assign offset      = on_chip_memory_address[OFFSET_W:1];
  assign index       = on_chip_memory_address[OFFSET_W+INDEX_W:OFFSET_W+1];
  assign tag         = on_chip_memory_address[ADDR_W-1:OFFSET_W+INDEX_W+1];
  assign addr_unused = on_chip_memory_address[0];

  state_t              state;
  logic [WAYS-1:0]     way_hit;
  logic                hit;
  logic                sel_way;
  logic                victim;
  logic                miss_start;
  logic [OFFSET_W-1:0] wb_offset;
  logic [OFFSET_W-1:0] fill_offset;
  logic                fill_we;
  logic                fill_done;
  logic [TAG_W-1:0]    victim_tag;
  logic [DATA_W-1:0]   wb_word;

  always_comb begin
    way_hit = '0;
    sel_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      way_hit[w] = valid_q[w][index] && (tag_mem[w][index] == tag);
      if (way_hit[w]) sel_way = 1'(w);
    end
  end

  assign hit      = enable & (|way_hit);
  assign data_out = hit ? data_mem[sel_way][{index, offset}] : '0;
  assign fsm_busy = (state != IDLE) | (enable & ~hit);

  // Invalid ways fill first (way 0 preferred); otherwise the LRU way goes.
  always_comb begin
    victim = 1'b0;
    if (WAYS > 1) begin
      if (!valid_q[0][index])           victim = 1'b0;
      else if (!valid_q[WAYS-1][index]) victim = 1'b1;
      else                              victim = lru_q[index];
    end
  end

  assign miss_start = (state == IDLE) & enable & ~hit;
  assign victim_tag = tag_mem[victim_q][index];
  assign wb_word    = data_mem[victim_q][{index, wb_offset}];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      dirty_q  <= '0;
      lru_q    <= '0;
      victim_q <= 1'b0;
    end else begin
      if (miss_start) victim_q <= victim;
      if (fill_done) begin
        valid_q[victim_q][index] <= 1'b1;
        dirty_q[victim_q][index] <= 1'b0;
      end
      if (hit) begin
        if (on_chip_wr) dirty_q[sel_way][index] <= 1'b1;
        if (WAYS > 1)   lru_q[index] <= ~sel_way;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we)          data_mem[victim_q][{index, fill_offset}] <= off_chip_memory_data;
    if (hit & on_chip_wr) data_mem[sel_way][{index, offset}]      <= on_chip_memory_data;
    if (fill_done)        tag_mem[victim_q][index]                <= tag;
  end

  cache_wb_fsm #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .SETS  (SETS),
    .WORDS (WORDS)
  ) u_fsm (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (miss_start),
    .victim_dirty           (dirty_q[victim][index]),
    .victim_tag             (victim_tag),
    .line_tag               (tag),
    .index                  (index),
    .wb_word                (wb_word),
    .mem_ready              (mem_ready),
    .memory_data_valid      (memory_data_valid),
    .state                  (state),
    .wb_offset              (wb_offset),
    .fill_offset            (fill_offset),
    .fill_we                (fill_we),
    .fill_done              (fill_done),
    .off_chip_rd            (off_chip_rd),
    .off_chip_wr            (off_chip_wr),
    .off_chip_memory_address(off_chip_memory_address),
    .off_chip_wr_data       (off_chip_wr_data)
  );

endmodule

// File: tb/tb_cache_wb_memory_system.sv
// Bench for cache_wb_memory_system: DRAM model with latency/back-pressure,
// CPU read scoreboard and an expected off-chip transaction queue.
module tb_cache_wb_memory_system;

  localparam int LAT   = 2;
  localparam int LIMIT = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        on_chip_wr;
  logic [15:0] on_chip_memory_address;
  logic [15:0] on_chip_memory_data;
  logic [15:0] data_out;
  logic        fsm_busy;
  logic [15:0] off_chip_memory_address;
  logic        off_chip_rd;
  logic        off_chip_wr;
  logic [15:0] off_chip_wr_data;
  logic        mem_ready;
  logic [15:0] off_chip_memory_data;
  logic        memory_data_valid;

  always #5 clk = ~clk;

  cache_wb_memory_system dut (
    .clk                    (clk),
    .rst                    (rst),
    .enable                 (enable),
    .on_chip_wr             (on_chip_wr),
    .on_chip_memory_address (on_chip_memory_address),
    .on_chip_memory_data    (on_chip_memory_data),
    .data_out               (data_out),
    .fsm_busy               (fsm_busy),
    .off_chip_memory_address(off_chip_memory_address),
    .off_chip_rd            (off_chip_rd),
    .off_chip_wr            (off_chip_wr),
    .off_chip_wr_data       (off_chip_wr_data),
    .mem_ready              (mem_ready),
    .off_chip_memory_data   (off_chip_memory_data),
    .memory_data_valid      (memory_data_valid)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] dram   [0:32767];
  logic [15:0] golden [0:32767];
  logic [15:0] exp_q[$];
  logic [32:0] bus_q[$];
  logic [14:0] pend_addr[$];
  int          pend_due[$];
  int          cyc    = 0;
  int          n_resp = 0;
  bit          bp      = 1'b0;
  bit          bus_chk = 1'b1;

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int w);
    return 16'((w * 40503) ^ 23130);
  endfunction

  // DRAM model: drives ready/response just after each falling edge and
  // samples the request that the next rising edge will see.
  initial begin
    logic        prev_req;
    logic [32:0] prev_bus;
    logic [32:0] cur;
    prev_req = 1'b0;
    prev_bus = '0;
    mem_ready = 1'b0;
    memory_data_valid = 1'b0;
    off_chip_memory_data = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      memory_data_valid    = 1'b0;
      off_chip_memory_data = '0;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
        mem_ready = 1'b0;
        prev_req  = 1'b0;
      end else begin
        mem_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (pend_due.size() > 0 && pend_due[0] <= cyc && (!bp || $urandom_range(0, 2) != 0)) begin
          memory_data_valid    = 1'b1;
          off_chip_memory_data = dram[pend_addr.pop_front()];
          void'(pend_due.pop_front());
          n_resp++;
        end
        cur = {off_chip_wr, off_chip_memory_address, off_chip_wr ? off_chip_wr_data : 16'h0};
        if (prev_req) check_eq("bus_hold", {6'd0, off_chip_rd | off_chip_wr, cur}, {6'd0, 1'b1, prev_bus});
        prev_req = 1'b0;
        if (off_chip_rd | off_chip_wr) begin
          if (mem_ready) begin
            check_eq("rd_wr_excl", 40'(off_chip_rd & off_chip_wr), 40'd0);
            if (bus_chk) begin
              check_eq("bus_expected", 40'(bus_q.size() != 0), 40'd1);
              if (bus_q.size() != 0) check_eq("bus_xfer", 40'(cur), 40'(bus_q.pop_front()));
            end
            if (off_chip_wr) dram[off_chip_memory_address[15:1]] = off_chip_wr_data;
            else begin
              pend_addr.push_back(off_chip_memory_address[15:1]);
              pend_due.push_back(cyc + LAT);
            end
          end else begin
            prev_req = 1'b1;
            prev_bus = cur;
          end
        end
      end
    end
  end

  task automatic exp_fill(input logic [15:0] base);
    for (int i = 0; i < 8; i++) bus_q.push_back({1'b0, 16'(base + 16'(2 * i)), 16'h0});
  endtask

  task automatic exp_wb(input logic [15:0] base);
    for (int i = 0; i < 8; i++)
      bus_q.push_back({1'b1, 16'(base + 16'(2 * i)), golden[base[15:1] + 15'(i)]});
  endtask

  task automatic access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input bit exp_hit);
    int n;
    @(negedge clk);
    enable                 = 1'b1;
    on_chip_wr             = wr;
    on_chip_memory_address = addr;
    on_chip_memory_data    = wdata;
    if (wr) golden[addr[15:1]] = wdata;
    else    exp_q.push_back(golden[addr[15:1]]);
    #2;
    if (exp_hit) check_eq("hit_not_busy", 40'(fsm_busy), 40'd0);
    n = 0;
    while (fsm_busy && n < LIMIT) begin
      @(negedge clk);
      #2;
      n++;
    end
    check_eq("done_in_time", 40'(fsm_busy), 40'd0);
    if (!wr && exp_q.size() != 0) check_eq("rd_data", 40'(data_out), 40'(exp_q.pop_front()));
    @(posedge clk);
    #1;
    enable = 1'b0;
    check_eq("bus_drained", 40'(bus_q.size()), 40'd0);
  endtask

  initial begin
    int n;
    int r0;
    rst = 1'b1;
    enable = 1'b0;
    on_chip_wr = 1'b0;
    on_chip_memory_address = '0;
    on_chip_memory_data = '0;
    for (int i = 0; i < 32768; i++) begin
      dram[i]   = pat(i);
      golden[i] = pat(i);
    end

    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_busy", 40'(fsm_busy), 40'd0);
    check_eq("rst_rd", 40'(off_chip_rd), 40'd0);
    check_eq("rst_wr", 40'(off_chip_wr), 40'd0);
    check_eq("rst_addr", 40'(off_chip_memory_address), 40'd0);
    check_eq("rst_wdata", 40'(off_chip_wr_data), 40'd0);
    check_eq("rst_dout", 40'(data_out), 40'd0);
    @(negedge clk);
    rst = 1'b0;

    // Cold read, then write hit and read-back.
    exp_fill(16'h1230);
    access(1'b0, 16'h1234, 16'h0, 1'b0);
    access(1'b1, 16'h1234, 16'hBEEF, 1'b1);
    access(1'b0, 16'h1234, 16'h0, 1'b1);

    // Set 0x23: fill other way, clean eviction, then dirty eviction.
    exp_fill(16'h5630);
    access(1'b0, 16'h5634, 16'h0, 1'b0);
    access(1'b0, 16'h1234, 16'h0, 1'b1);
    exp_fill(16'h9A30);
    access(1'b0, 16'h9A34, 16'h0, 1'b0);
    exp_wb(16'h1230);
    exp_fill(16'hDE30);
    access(1'b0, 16'hDE34, 16'h0, 1'b0);
    exp_fill(16'h1230);
    access(1'b0, 16'h1234, 16'h0, 1'b0);

    // Enable low: no state change, no traffic.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      enable                 = 1'b0;
      on_chip_wr             = ($urandom_range(0, 1) == 1);
      on_chip_memory_address = 16'($urandom);
      on_chip_memory_data    = 16'($urandom);
      #2;
      check_eq("idle_busy", 40'(fsm_busy), 40'd0);
    end
    access(1'b0, 16'h1234, 16'h0, 1'b1);
    access(1'b0, 16'hDE34, 16'h0, 1'b1);

    // Back-pressure on both request and response paths.
    bp = 1'b1;
    exp_fill(16'h4460);
    access(1'b1, 16'h4468, 16'h1357, 1'b0);
    for (int i = 0; i < 8; i++) access(1'b0, 16'(16'h4460 + 16'(2 * i)), 16'h0, 1'b1);
    exp_fill(16'h8460);
    access(1'b0, 16'h8462, 16'h0, 1'b0);
    exp_wb(16'h4460);
    exp_fill(16'hC460);
    access(1'b0, 16'hC46E, 16'h0, 1'b0);
    exp_fill(16'h4460);
    access(1'b0, 16'h4468, 16'h0, 1'b0);
    bp = 1'b0;

    // Reset in the middle of a fill.
    bus_chk = 1'b0;
    r0 = n_resp;
    @(negedge clk);
    enable                 = 1'b1;
    on_chip_wr             = 1'b0;
    on_chip_memory_address = 16'h2004;
    n = 0;
    while (n_resp - r0 < 3 && n < LIMIT) begin
      @(negedge clk);
      #2;
      n++;
    end
    check_eq("resp3_seen", 40'(n_resp - r0), 40'd3);
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    #2;
    check_eq("midrst_busy", 40'(fsm_busy), 40'd0);
    check_eq("midrst_rd", 40'(off_chip_rd), 40'd0);
    rst = 1'b0;
    bus_q.delete();
    bus_chk = 1'b1;
    exp_fill(16'h2000);
    access(1'b0, 16'h2004, 16'h0, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
